// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: accepts one core request, runs one bus
// access with a timeout, and returns a one-cycle response pulse.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [29:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    localparam logic [7:0] CntMax = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StBus;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                end
            end
            StBus: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wb_ack_i) begin
                    state_d     = StResp;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CntMax) begin
                    state_d     = StResp;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: a 16-word RAM responder with selectable ack timing
// and hand-computed expectations for latency, data, timeout and reset behaviour.
module tb_wb_initiator;

    logic        clk;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [3:0]  req_sel_i;
    logic [29:0] req_adr_i;
    logic [31:0] req_dat_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int errors = 0;
    int checks = 0;

    // 0: comb ack, 1: ack on 2nd strobe cycle, 2: never, 3: ack on 4th strobe cycle,
    // 4: ack held high regardless of strobe
    int          ack_mode = 0;
    int          stb_cyc;
    logic [31:0] mem [16];

    wb_initiator #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_sel_i   (req_sel_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) stb_cyc <= 0;
        else         stb_cyc <= wb_stb_o ? stb_cyc + 1 : 0;
    end

    always_comb begin
        wb_ack_i = 1'b0;
        case (ack_mode)
            0: wb_ack_i = wb_stb_o;
            1: wb_ack_i = wb_stb_o && (stb_cyc == 1);
            3: wb_ack_i = wb_stb_o && (stb_cyc == 3);
            4: wb_ack_i = 1'b1;
            default: wb_ack_i = 1'b0;
        endcase
    end

    assign wb_dat_i = mem[wb_adr_o[3:0]];

    always @(posedge clk) begin
        if (wb_stb_o && wb_ack_i && wb_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_o[b]) mem[wb_adr_o[3:0]][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                         input logic [31:0] dat);
        req_we_i    = we;
        req_sel_i   = sel;
        req_adr_i   = adr;
        req_dat_i   = dat;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic access(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                          input logic [31:0] dat, input int mode,
                          output int stb_n, output int lat, output logic [31:0] rdat,
                          output logic rerr, output int unstable, output logic pulse_after,
                          output logic ready_after, output logic [31:0] held_dat);
        ack_mode = mode;
        stb_n    = 0;
        lat      = -1;
        unstable = 0;
        rdat     = '0;
        rerr     = 1'b0;
        issue(we, sel, adr, dat);
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (wb_stb_o) begin
                stb_n++;
                if (wb_we_o !== we || wb_sel_o !== sel || wb_adr_o !== adr || wb_dat_o !== dat)
                    unstable++;
            end
            if (rsp_valid_o) begin
                lat  = k;
                rdat = rsp_dat_o;
                rerr = rsp_err_o;
            end
        end
        @(negedge clk);
        pulse_after = rsp_valid_o;
        ready_after = req_ready_o;
        held_dat    = rsp_dat_o;
    endtask

    int          stb_n, lat, unstable;
    logic [31:0] rdat, held;
    logic        rerr, pulse_after, ready_after;
    int          seen_valid;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_sel_i   = '0;
        req_adr_i   = '0;
        req_dat_i   = '0;

        #1;
        chk("reset_cyc", 32'(wb_cyc_o), 32'h0);
        chk("reset_stb", 32'(wb_stb_o), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err_o), 32'h0);
        chk("reset_rsp_dat", rsp_dat_o, 32'h0);
        chk("reset_adr", 32'(wb_adr_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready_o), 32'h1);

        // Full write, combinational ack
        access(1'b1, 4'hF, 30'h10, 32'hDEADBEEF, 0, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("wr_stb_cycles", 32'(stb_n), 32'd1);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_err", 32'(rerr), 32'h0);
        chk("wr_rsp_dat", rdat, 32'h0);
        chk("wr_pulse_once", 32'(pulse_after), 32'h0);
        chk("wr_ready_after", 32'(ready_after), 32'h1);
        chk("wr_stable", 32'(unstable), 32'd0);

        // Read with ack one cycle late
        access(1'b0, 4'hF, 30'h10, 32'h0, 1, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("rd_stb_cycles", 32'(stb_n), 32'd2);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_dat", rdat, 32'hDEADBEEF);
        chk("rd_err", 32'(rerr), 32'h0);
        chk("rd_pulse_once", 32'(pulse_after), 32'h0);
        chk("rd_dat_held", held, 32'hDEADBEEF);
        chk("rd_stable", 32'(unstable), 32'd0);

        // Partial write over a known word, then read back
        access(1'b1, 4'hF, 30'h5, 32'h11223344, 0, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("pw_full_latency", 32'(lat), 32'd2);
        access(1'b1, 4'h2, 30'h5, 32'h0000AB00, 0, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("pw_part_latency", 32'(lat), 32'd2);
        chk("pw_part_stable", 32'(unstable), 32'd0);
        access(1'b0, 4'hF, 30'h5, 32'h0, 1, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("pw_readback", rdat, 32'h1122AB44);

        // No ack: timeout after 4 strobe cycles
        access(1'b0, 4'hF, 30'h5, 32'h0, 2, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("to_stb_cycles", 32'(stb_n), 32'd4);
        chk("to_latency", 32'(lat), 32'd5);
        chk("to_err", 32'(rerr), 32'h1);
        chk("to_dat", rdat, 32'h0);
        chk("to_err_held", 32'(rsp_err_o), 32'h1);

        // Ack in the very cycle the timeout expires
        access(1'b0, 4'hF, 30'h10, 32'h0, 3, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("race_stb_cycles", 32'(stb_n), 32'd4);
        chk("race_latency", 32'(lat), 32'd5);
        chk("race_err", 32'(rerr), 32'h0);
        chk("race_dat", rdat, 32'hDEADBEEF);

        // Ack while idle is ignored
        ack_mode = 4;
        @(negedge clk);
        chk("idle_ack_valid", 32'(rsp_valid_o), 32'h0);
        chk("idle_ack_cyc", 32'(wb_cyc_o), 32'h0);
        @(negedge clk);
        chk("idle_ack_ready", 32'(req_ready_o), 32'h1);
        chk("idle_ack_valid2", 32'(rsp_valid_o), 32'h0);

        // Reset in the middle of a read
        ack_mode = 2;
        issue(1'b0, 4'hF, 30'h10, 32'h0);
        @(negedge clk);
        chk("mid_cyc_before", 32'(wb_cyc_o), 32'h1);
        @(negedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_cyc_async", 32'(wb_cyc_o), 32'h0);
        chk("mid_stb_async", 32'(wb_stb_o), 32'h0);
        seen_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid_o) seen_valid++;
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid_o) seen_valid++;
        end
        chk("mid_no_rsp", 32'(seen_valid), 32'd0);
        chk("mid_rsp_dat_cleared", rsp_dat_o, 32'h0);
        chk("mid_ready", 32'(req_ready_o), 32'h1);

        access(1'b1, 4'hF, 30'h3, 32'hCAFEF00D, 0, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("post_wr_latency", 32'(lat), 32'd2);
        access(1'b0, 4'hF, 30'h3, 32'h0, 1, stb_n, lat, rdat, rerr, unstable,
               pulse_after, ready_after, held);
        chk("post_rd_latency", 32'(lat), 32'd3);
        chk("post_rd_dat", rdat, 32'hCAFEF00D);
        chk("post_rd_err", 32'(rerr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
